lpm_pack_seq: RTL



---
 rtl/lpm_pack_seq_pkg.sv | 14 +
 rtl/lpm_pack_seq_if.sv | 39 +++
 rtl/lpm_pack_seq.sv | 88 ++++++++
 3 files changed

// File: rtl/lpm_pack_seq_pkg.sv
// Shared definitions for the LPM word packer: state encodings and count-width helper.
package lpm_pack_seq_pkg;

  typedef enum logic {
    LPM_PACK_FILL = 1'b0,
    LPM_PACK_FULL = 1'b1
  } pack_state_t;

  // Width of the held-word counter, which must be able to represent lpm_size itself.
  function automatic int count_width(input int size);
    return (size < 1) ? 1 : $clog2(size + 1);
  endfunction

endpackage

// File: rtl/lpm_pack_seq_if.sv
// Handshake bundle between word producer, packer and frame consumer.
// Carries the optional running-OR output when LPM_PACK_SEQ_OR_RESULT_EN is defined.
interface lpm_pack_seq_if #(
  parameter int lpm_width = 1,
  parameter int lpm_size  = 1
);
  import lpm_pack_seq_pkg::*;

  localparam int CNT_W = count_width(lpm_size);

  logic [lpm_width-1:0]          data_in;
  logic                          in_valid;
  logic                          in_ready;
  logic                          flush;
  logic [lpm_size*lpm_width-1:0] data;
  logic                          out_valid;
  logic                          out_ready;
  logic [CNT_W-1:0]              count;
`ifdef LPM_PACK_SEQ_OR_RESULT_EN
  logic [lpm_width-1:0]          result;
`endif

  modport master (
    output data_in, in_valid, flush, out_ready,
    input  in_ready, data, out_valid, count
`ifdef LPM_PACK_SEQ_OR_RESULT_EN
    , input result
`endif
  );

  modport slave (
    input  data_in, in_valid, flush, out_ready,
    output in_ready, data, out_valid, count
`ifdef LPM_PACK_SEQ_OR_RESULT_EN
    , output result
`endif
  );

endinterface

// File: rtl/lpm_pack_seq.sv
// Sequential packer: gathers lpm_size words of lpm_width bits into one frame for the OR reducer.
// Define LPM_PACK_SEQ_OR_RESULT_EN to add a registered running OR of the frame on bus.result.
module lpm_pack_seq
  import lpm_pack_seq_pkg::*;
#(
  parameter         lpm_type  = "lpm_pack_seq",
  parameter int     lpm_width = 1,
  parameter int     lpm_size  = 1,
  parameter         lpm_hint  = "UNUSED"
) (
  input logic           clock,
  input logic           sclr,
  lpm_pack_seq_if.slave bus
);

  localparam int FRAME_W = lpm_size * lpm_width;
  localparam int CNT_W   = count_width(lpm_size);

  if (lpm_width < 1 || lpm_size < 1) begin : g_bad_dims
    $error("lpm_pack_seq: lpm_width and lpm_size must be at least 1");
  end
  if (lpm_type != "lpm_pack_seq" || lpm_hint == "") begin : g_bad_id
    $error("lpm_pack_seq: unexpected identification parameters");
  end

  pack_state_t        state;
  logic [FRAME_W-1:0] frame;
  logic [CNT_W-1:0]   held;
  logic               accept;
  logic               drain;
  logic               last_word;
  int                 slot;

  assign bus.in_ready  = (state == LPM_PACK_FILL) | bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;
  assign drain         = (state == LPM_PACK_FULL) & bus.out_ready;
  assign slot          = int'(held) * lpm_width;
  assign last_word     = (int'(held) + 1 == lpm_size);

  assign bus.data      = frame;
  assign bus.count     = held;
  assign bus.out_valid = (state == LPM_PACK_FULL);

  always_ff @(posedge clock) begin
    if (sclr) begin
      state <= LPM_PACK_FILL;
      frame <= '0;
      held  <= '0;
    end else begin
      case (state)
        LPM_PACK_FILL: begin
          if (accept) begin
            frame[slot +: lpm_width] <= bus.data_in;
            held                     <= held + CNT_W'(1);
          end
          // A flush closes the frame only if it will hold at least one word.
          if ((accept && last_word) || (bus.flush && (accept || held != '0)))
            state <= LPM_PACK_FULL;
        end
        LPM_PACK_FULL: begin
          if (drain) begin
            frame <= accept ? FRAME_W'(bus.data_in) : '0;
            held  <= accept ? CNT_W'(1) : '0;
            state <= (accept && lpm_size == 1) ? LPM_PACK_FULL : LPM_PACK_FILL;
          end
        end
      endcase
    end
  end

`ifdef LPM_PACK_SEQ_OR_RESULT_EN
  logic [lpm_width-1:0] run_or;

  always_ff @(posedge clock) begin
    if (sclr) begin
      run_or <= '0;
    end else if (state == LPM_PACK_FILL) begin
      if (accept)
        run_or <= run_or | bus.data_in;
    end else if (drain) begin
      run_or <= accept ? bus.data_in : '0;
    end
  end

  assign bus.result = run_or;
`endif

endmodule
